// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel scanner: scan state encoding and the
// gamma-2.2 curve used to build per-channel lookup tables.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

  // Gamma-2.2 entry for code v of a w-bit channel, rounded to nearest.
  // Evaluated at elaboration only, to fill constant tables.
  function automatic int gamma_val(input int v, input int w);
    real m;
    real x;
    if (v <= 0) return 0;
    m = $itor((1 << w) - 1);
    x = $itor(v) / m;
    return $rtoi($exp(2.2 * $ln(x)) * m + 0.5);
  endfunction

endpackage

// File: rtl/hub75_gamma.sv
// Combinational gamma-2.2 lookup for one W-bit colour channel; the table is a
// constant built from hub75_pkg::gamma_val.
module hub75_gamma
  import hub75_pkg::*;
#(
  parameter int W = 8
)(
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] lut [2**W];

  for (genvar i = 0; i < 2**W; i++) begin : g_lut
    localparam int G = gamma_val(i, W);
    assign lut[i] = G[W-1:0];
  end

  assign dout = lut[din];

endmodule

// File: rtl/hub75_scan.sv
// HUB75 panel scanner: shifts one bit-plane of two half-panel rows, latches it
// and displays it for a binary-weighted time. Build option: HUB75_SCAN_GAMMA_EN.
module hub75_scan
  import hub75_pkg::*;
#(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8,
  parameter int base_p   = 4
)(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_enable,
  output logic [$clog2(hpixel_p*vpixel_p)-1:0] o_rd_addr,
  input  logic [2:0][bpp_p-1:0]                i_rd_data,
  output logic [2:0]                           o_rgb_top,
  output logic [2:0]                           o_rgb_bot,
  output logic                                 o_clk,
  output logic                                 o_lat,
  output logic                                 o_oe_n,
  output logic [$clog2(vpixel_p/2)-1:0]        o_addr,
  output logic                                 o_frame_done
);

  localparam int AW = $clog2(hpixel_p*vpixel_p);
  localparam int RW = $clog2(vpixel_p/2);
  localparam int CW = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int BW = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int DW = $clog2((base_p << (bpp_p-1)) + 1);

  scan_state_e       state, state_d;
  logic [1:0]        phase;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [BW-1:0]     plane;
  logic [DW-1:0]     dcnt;
  logic [2:0]        top_q, sel;
  logic [2:0][bpp_p-1:0] px;
  logic [AW-1:0]     top_addr, bot_addr;
  logic              last_col, last_row, last_plane;

  assign last_col   = (col == CW'(hpixel_p-1));
  assign last_row   = (row == RW'(vpixel_p/2-1));
  assign last_plane = (plane == BW'(bpp_p-1));
  assign top_addr   = AW'(32'(row) * hpixel_p + 32'(col));
  assign bot_addr   = AW'((32'(row) + vpixel_p/2) * hpixel_p + 32'(col));

`ifdef HUB75_SCAN_GAMMA_EN
  for (genvar c = 0; c < 3; c++) begin : g_gamma
    hub75_gamma #(.W(bpp_p)) u_gamma (.din(i_rd_data[c]), .dout(px[c]));
  end
`else
  assign px = i_rd_data;
`endif

  always_comb begin
    for (int c = 0; c < 3; c++) sel[c] = px[c][plane];
  end

  // Panel strobes are decoded from state so reset blanks the panel at once.
  always_comb begin
    state_d   = state;
    o_clk     = 1'b0;
    o_lat     = 1'b0;
    o_oe_n    = 1'b1;
    o_rd_addr = top_addr;
    unique case (state)
      ST_IDLE: if (i_enable) state_d = ST_SHIFT;
      ST_SHIFT: begin
        o_clk = (phase == 2'd3);
        if (phase == 2'd1) o_rd_addr = bot_addr;
        if (phase == 2'd3 && last_col) state_d = ST_BLANK;
      end
      ST_BLANK: state_d = ST_LATCH;
      ST_LATCH: begin
        o_lat   = 1'b1;
        state_d = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        o_oe_n = 1'b0;
        if (dcnt == '0) state_d = i_enable ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      phase        <= '0;
      col          <= '0;
      row          <= '0;
      plane        <= '0;
      dcnt         <= '0;
      top_q        <= '0;
      o_rgb_top    <= '0;
      o_rgb_bot    <= '0;
      o_addr       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_d;
      o_frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: if (i_enable) begin
          row   <= '0;
          plane <= '0;
        end
        ST_SHIFT: begin
          phase <= phase + 2'd1;
          if (phase == 2'd1) top_q <= sel;
          // bottom data arrives in phase 2, so it goes straight to the pins
          if (phase == 2'd2) begin
            o_rgb_top <= top_q;
            o_rgb_bot <= sel;
          end
          if (phase == 2'd3) col <= last_col ? '0 : col + CW'(1);
        end
        ST_BLANK:   o_addr <= row;
        ST_LATCH:   dcnt   <= DW'((base_p << plane) - 1);
        ST_DISPLAY: begin
          if (dcnt != '0) begin
            dcnt <= dcnt - DW'(1);
          end else if (last_plane) begin
            plane <= '0;
            if (last_row) begin
              row          <= '0;
              o_frame_done <= 1'b1;
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            plane <= plane + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan.sv
// Directed bench for hub75_scan on a 4x4 panel, 2 bpp, base 1: a scoreboard of
// per-column RGB, latched row address and display length feeds a monitor.
module tb_hub75_scan;

  localparam int HP = 4, VP = 4, BPP = 2, BASE = 1;
  localparam int AW = $clog2(HP*VP);
  localparam int RW = $clog2(VP/2);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_enable = 1'b0;
  logic [AW-1:0]         o_rd_addr;
  logic [2:0][BPP-1:0]   i_rd_data;
  logic [2:0]            o_rgb_top, o_rgb_bot;
  logic                  o_clk, o_lat, o_oe_n, o_frame_done;
  logic [RW-1:0]         o_addr;

  logic [2:0][BPP-1:0]   fb [HP*VP];
  logic [5:0]            exp_px_q [$];
  logic [RW-1:0]         exp_addr_q [$];
  int                    exp_disp_q [$];

  int n_assert = 0, n_fail = 0;
  int rise_cnt = 0, lat_cnt = 0, done_cnt = 0, run = 0;
  logic p_clk = 1'b0, p_oe_n = 1'b1;
  logic [RW-1:0] p_addr = '0;
  logic [2:0] exp3;

  hub75_scan #(.hpixel_p(HP), .vpixel_p(VP), .bpp_p(BPP), .base_p(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_rgb_top(o_rgb_top), .o_rgb_bot(o_rgb_bot),
    .o_clk(o_clk), .o_lat(o_lat), .o_oe_n(o_oe_n),
    .o_addr(o_addr), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  // framebuffer with one cycle of read latency
  always @(posedge clk) i_rd_data <= fb[o_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BPP-1:0] gam(input logic [BPP-1:0] v);
`ifdef HUB75_SCAN_GAMMA_EN
    int g;
    g = hub75_pkg::gamma_val(int'(v), BPP);
    return g[BPP-1:0];
`else
    return v;
`endif
  endfunction

  function automatic logic [2:0] chan_bits(input int addr, input int b);
    logic [2:0] r;
    logic [BPP-1:0] g;
    for (int c = 0; c < 3; c++) begin
      g = gam(fb[addr][c]);
      r[c] = g[b];
    end
    return r;
  endfunction

  task automatic push_plane(input int row, input int b, input bit with_disp);
    for (int c = 0; c < HP; c++)
      exp_px_q.push_back({chan_bits(row*HP + c, b), chan_bits((row + VP/2)*HP + c, b)});
    exp_addr_q.push_back(RW'(row));
    if (with_disp) exp_disp_q.push_back(BASE << b);
  endtask

  task automatic wait_cnt(input string tag, input int which, input int target);
    int v;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      v = (which == 0) ? rise_cnt : (which == 1) ? lat_cnt : done_cnt;
      if (v >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_reached"}, 32'(ok), 1);
  endtask

  // monitor: sampled on the falling edge, away from DUT updates
  always @(negedge clk) begin
    if (!rst_n) begin
      run    <= 0;
      p_clk  <= 1'b0;
      p_oe_n <= 1'b1;
    end else begin
      chk("lat_with_oe", 32'(o_lat && !o_oe_n), 0);
      if (!p_oe_n && !o_oe_n) chk("addr_hold_oe", 32'(o_addr), 32'(p_addr));
      if (o_clk && !p_clk) begin
        rise_cnt <= rise_cnt + 1;
        if (exp_px_q.size() == 0) chk("px_underflow", 1, 0);
        else chk("px_rgb", 32'({o_rgb_top, o_rgb_bot}), 32'(exp_px_q.pop_front()));
      end
      if (o_lat) begin
        lat_cnt <= lat_cnt + 1;
        if (exp_addr_q.size() == 0) chk("addr_underflow", 1, 0);
        else chk("latch_addr", 32'(o_addr), 32'(exp_addr_q.pop_front()));
      end
      if (!o_oe_n) run <= run + 1;
      else if (run > 0) begin
        if (exp_disp_q.size() == 0) chk("disp_underflow", 1, 0);
        else chk("disp_len", 32'(run), 32'(exp_disp_q.pop_front()));
        run <= 0;
      end
      if (o_frame_done) done_cnt <= done_cnt + 1;
      p_clk  <= o_clk;
      p_oe_n <= o_oe_n;
      p_addr <= o_addr;
    end
  end

  initial begin
    for (int a = 0; a < HP*VP; a++)
      for (int c = 0; c < 3; c++) fb[a][c] = BPP'($urandom);
    fb[2]  = {2'b00, 2'b00, 2'b10};   // row0,col2: R=10
    fb[10] = {2'b01, 2'b00, 2'b00};   // row2,col2: B=01

    #3;
    chk("rst_oe_n", 32'(o_oe_n), 1);
    chk("rst_clk", 32'(o_clk), 0);
    chk("rst_lat", 32'(o_lat), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_rgb_top", 32'(o_rgb_top), 0);
    chk("rst_rgb_bot", 32'(o_rgb_bot), 0);
    chk("rst_rd_addr", 32'(o_rd_addr), 0);
    chk("rst_frame_done", 32'(o_frame_done), 0);

    @(negedge clk); rst_n = 1'b1;
    push_plane(0, 0, 1); push_plane(0, 1, 1);
    push_plane(1, 0, 1); push_plane(1, 1, 1);
    push_plane(0, 0, 1); push_plane(0, 1, 1);

    @(posedge clk); #1 i_enable = 1'b1;
    @(posedge clk); #1 chk("rd_addr_ph0", 32'(o_rd_addr), 0);
    @(posedge clk); #1 chk("rd_addr_ph1", 32'(o_rd_addr), 8);

`ifdef HUB75_SCAN_GAMMA_EN
    exp3 = chan_bits(10, 0);
`else
    exp3 = 3'b100;
`endif
    wait_cnt("rise3", 0, 3);
    chk("bot_bit0_col2", 32'(o_rgb_bot), 32'(exp3));
`ifdef HUB75_SCAN_GAMMA_EN
    exp3 = chan_bits(2, 1);
`else
    exp3 = 3'b001;
`endif
    wait_cnt("rise7", 0, 7);
    chk("top_bit1_col2", 32'(o_rgb_top), 32'(exp3));

    wait_cnt("frame_done", 2, 1);
    wait_cnt("latch5", 1, 5);
    chk("frame_done_count", 32'(done_cnt), 1);

    // drop enable early in the next plane's shift
    repeat (4) @(posedge clk);
    #1 i_enable = 1'b0;
    repeat (40) @(posedge clk);
    chk("plane_completed", 32'(lat_cnt), 6);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("idle_oe_n", 32'(o_oe_n), 1);
      chk("idle_clk", 32'(o_clk), 0);
    end

    push_plane(0, 0, 0);
    i_enable = 1'b1;
    @(posedge clk); #1 chk("resume_ph0", 32'(o_rd_addr), 0);
    @(posedge clk); #1 chk("resume_ph1", 32'(o_rd_addr), 8);
    wait_cnt("latch7", 1, 7);
    chk("in_display", 32'(o_oe_n), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_oe_n", 32'(o_oe_n), 1);
    chk("async_rst_lat", 32'(o_lat), 0);

    #20 rst_n = 1'b1;
    i_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("px_q_empty", 32'(exp_px_q.size()), 0);
    chk("addr_q_empty", 32'(exp_addr_q.size()), 0);
    chk("disp_q_empty", 32'(exp_disp_q.size()), 0);
    chk("final_frame_done", 32'(done_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_scan.md
HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 SHALL have parameters: hpixel_p, default 64, panel width in pixels; vpixel_p, default 64, panel height in pixels; bpp_p, default 8, bits per colour channel; base_p, default 4, display clk cycles for the LSB bit-plane.
REQ-002 SHALL have ports: clk  input  1  single clock; rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: i_enable  input  1  start/continue scanning.
REQ-004 SHALL have: o_rd_addr  output  $clog2(hpixel_p*vpixel_p)  framebuffer read address, linear index row*hpixel_p+col.
REQ-005 SHALL have: i_rd_data  input  [2:0][bpp_p-1:0]  framebuffer read data, valid exactly 1 clk after o_rd_addr; index 0=R, 1=G, 2=B.
REQ-006 SHALL have: o_rgb_top  output  3  panel R1,G1,B1; o_rgb_bot  output  3  panel R2,G2,B2.
REQ-007 SHALL have: o_clk  output  1  panel shift clock; o_lat  output  1  panel latch; o_oe_n  output  1  panel output enable, active-low.
REQ-008 SHALL have: o_addr  output  $clog2(vpixel_p/2)  panel row address; o_frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-009 SHALL scan with states IDLE, SHIFT, BLANK, LATCH, DISPLAY.
REQ-010 IDLE: o_oe_n=1; leave to SHIFT with row=0, bit=0 on the first clk where i_enable=1.
REQ-011 SHIFT: hpixel_p columns, each exactly 4 clk, phases 0..3.
REQ-012 Phase 0: o_rd_addr=row*hpixel_p+col, o_clk=0.
REQ-013 Phase 1: o_rd_addr=(row+vpixel_p/2)*hpixel_p+col; capture bit [bit] of each channel of i_rd_data into top register.
REQ-014 Phase 2: capture bit [bit] of i_rd_data into bottom register; o_rgb_top/o_rgb_bot update from registers at end of phase 2.
REQ-015 Phase 3: o_clk=1; RGB stable for all of phase 3.
REQ-016 o_clk SHALL be 1 only in phase 3; RGB SHALL never change while o_clk=1.
REQ-017 BLANK: 1 clk, o_oe_n=1, o_addr<=row.
REQ-018 LATCH: 1 clk, o_lat=1, o_oe_n=1.
REQ-019 DISPLAY: o_oe_n=0 for exactly base_p<<bit clk, o_addr held.
REQ-020 After DISPLAY, bit increments; at bit=bpp_p-1, bit wraps to 0 and row increments; at row=vpixel_p/2-1, row wraps to 0 and o_frame_done pulses 1 clk.
REQ-021 o_addr SHALL change only while o_oe_n=1.
REQ-022 After DISPLAY, if i_enable=0, go to IDLE; a plane in progress always completes.
REQ-023 Row/bit SHALL be retained across IDLE; restart resumes at row=0, bit=0.
REQ-024 Display counter width SHALL hold base_p<<(bpp_p-1) without overflow.
REQ-025 o_lat and o_oe_n=0 SHALL never be asserted together.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, row=0, bit=0, o_oe_n=1.
REQ-027 On rst_n=0, asynchronously: o_clk=0, o_lat=0, o_addr=0, o_rgb_*=0, o_rd_addr=0, o_frame_done=0.
REQ-028 Reset mid-DISPLAY SHALL blank the panel immediately.

Configuration
REQ-029 With HUB75_SCAN_GAMMA_EN defined, each channel value SHALL pass through a bpp_p-wide gamma-2.2 lookup before bit selection, combinationally, with no change to phase timing.
REQ-030 Without HUB75_SCAN_GAMMA_EN, raw channel bits SHALL be used and no gamma logic SHALL exist.

Structure
REQ-031 Shared package hub75_pkg SHALL hold the scan state enum and the gamma table constant/function.
REQ-032 Gamma lookup SHALL be sub-module hub75_gamma, instantiated per channel only under HUB75_SCAN_GAMMA_EN.

Verification (hpixel_p=4, vpixel_p=4, bpp_p=2, base_p=1 unless stated)
REQ-033 Reset, then i_enable=1 -> o_rd_addr sequence 0,8,... for column 0, row 0; 4 o_clk pulses, then BLANK, 1-clk o_lat, o_oe_n=0 for 1 clk (bit 0), then 2 clk (bit 1).
REQ-034 Frame pixel (row0,col2)=R 2'b10, pixel (row2,col2)=B 2'b01 -> bit 0: o_rgb_bot=3'b100 at 3rd o_clk rise; bit 1: o_rgb_top=3'b001.
REQ-035 Run full frame -> o_addr 0,1,0; exactly one o_frame_done pulse per 2 rows x 2 planes; o_addr never changes while o_oe_n=0.
REQ-036 Drop i_enable mid-SHIFT -> current plane completes, then IDLE with o_oe_n=1; re-assert -> scan resumes.
REQ-037 Assert rst_n=0 mid-DISPLAY -> o_oe_n=1 and o_lat=0 in the same cycle, with no clock edge needed.
REQ-038 With HUB75_SCAN_GAMMA_EN, bpp_p=8: pixel 8'd128 -> bit pattern on the panel equals the gamma table entry 128.
